lcd_ctrl: RTL



---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_ctrl_if.sv | 10 +
 rtl/lcd_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD bus driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EN_HI,
    HOLD,
    EXEC,
    PWRUP
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME      = 8'h02;
  localparam logic [7:0] LCD_CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY_INC = 8'h06;

  // Power-on command sequence, element 0 is issued first.
  localparam int INIT_LEN = 4;
  localparam logic [INIT_LEN-1:0][7:0] INIT_SEQ = {
    LCD_CMD_ENTRY_INC, LCD_CMD_CLEAR, LCD_CMD_DISP_ON, LCD_CMD_FUNC_8B2L
  };

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// Request handshake between the core's LCD register and the LCD bus driver.
interface lcd_ctrl_if;
  logic       valid;
  logic       ready;
  logic       rs;
  logic [7:0] data;

  modport master (output valid, output rs, output data, input ready);
  modport slave  (input valid, input rs, input data, output ready);
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780 bus driver: takes one command/data byte per handshake and generates
// the RS/DATA setup, EN pulse, hold and execution wait on the LCD pins.
// Optional build macro LCD_INIT_EN: after reset, wait the power-up time and
// issue the init command sequence before accepting requests.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 2500,
  parameter int T_CLEAR_CYC = 82000,
  parameter int T_PWRUP_CYC = 750000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  lcd_ctrl_if.slave  req,
  input  logic       lcd_on_i,
  output logic       busy_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rw_o,
  output logic       lcd_rs_o,
  output logic       lcd_en_o,
  output logic       lcd_on_o
);

  localparam int MAX_CYC = max2(max2(max2(T_SETUP_CYC, T_EN_CYC), max2(T_HOLD_CYC, T_EXEC_CYC)),
                                max2(T_CLEAR_CYC, T_PWRUP_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  typedef logic [CNT_W-1:0] cnt_t;

`ifdef LCD_INIT_EN
  localparam lcd_state_e RST_STATE = PWRUP;
  localparam cnt_t       RST_CNT   = cnt_t'(T_PWRUP_CYC);
  localparam logic       RST_READY = 1'b0;
  typedef logic [$clog2(INIT_LEN)-1:0] idx_t;
  idx_t idx, idx_n;
  logic init_done, init_done_n;
`else
  localparam lcd_state_e RST_STATE = IDLE;
  localparam cnt_t       RST_CNT   = '0;
  localparam logic       RST_READY = 1'b1;
`endif

  lcd_state_e state, state_n;
  cnt_t       cnt, cnt_n;
  logic [7:0] data_n;
  logic       rs_n;
  logic       last;

  assign last     = (cnt <= cnt_t'(1));
  assign lcd_rw_o = 1'b0;

  // Next-state, counter reload and byte-latch selection.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    data_n  = lcd_data_o;
    rs_n    = lcd_rs_o;
`ifdef LCD_INIT_EN
    idx_n       = idx;
    init_done_n = init_done;
`endif
    case (state)
      IDLE: begin
        if (req.valid && req.ready) begin
          state_n = SETUP;
          cnt_n   = cnt_t'(T_SETUP_CYC);
          data_n  = req.data;
          rs_n    = req.rs;
        end
      end
      SETUP: begin
        if (last) begin
          state_n = EN_HI;
          cnt_n   = cnt_t'(T_EN_CYC);
        end else begin
          cnt_n = cnt - cnt_t'(1);
        end
      end
      EN_HI: begin
        if (last) begin
          state_n = HOLD;
          cnt_n   = cnt_t'(T_HOLD_CYC);
        end else begin
          cnt_n = cnt - cnt_t'(1);
        end
      end
      HOLD: begin
        if (last) begin
          state_n = EXEC;
          cnt_n   = is_slow_cmd(lcd_rs_o, lcd_data_o) ? cnt_t'(T_CLEAR_CYC) : cnt_t'(T_EXEC_CYC);
        end else begin
          cnt_n = cnt - cnt_t'(1);
        end
      end
      EXEC: begin
        if (last) begin
          state_n = IDLE;
`ifdef LCD_INIT_EN
          // Chain straight into the next init byte without passing through IDLE.
          if (!init_done) begin
            if (idx == idx_t'(INIT_LEN - 1)) begin
              init_done_n = 1'b1;
            end else begin
              idx_n   = idx + idx_t'(1);
              state_n = SETUP;
              cnt_n   = cnt_t'(T_SETUP_CYC);
              data_n  = INIT_SEQ[idx + idx_t'(1)];
              rs_n    = 1'b0;
            end
          end
`endif
        end else begin
          cnt_n = cnt - cnt_t'(1);
        end
      end
`ifdef LCD_INIT_EN
      PWRUP: begin
        if (last) begin
          state_n = SETUP;
          cnt_n   = cnt_t'(T_SETUP_CYC);
          data_n  = INIT_SEQ[0];
          rs_n    = 1'b0;
        end else begin
          cnt_n = cnt - cnt_t'(1);
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // State, counter and registered LCD/handshake outputs; EN clears asynchronously on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= RST_STATE;
      cnt        <= RST_CNT;
      lcd_data_o <= 8'h00;
      lcd_rs_o   <= 1'b0;
      lcd_en_o   <= 1'b0;
      req.ready  <= RST_READY;
      busy_o     <= !RST_READY;
`ifdef LCD_INIT_EN
      idx        <= '0;
      init_done  <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      lcd_data_o <= data_n;
      lcd_rs_o   <= rs_n;
      lcd_en_o   <= (state_n == EN_HI);
      req.ready  <= (state_n == IDLE);
      busy_o     <= (state_n != IDLE);
`ifdef LCD_INIT_EN
      idx        <= idx_n;
      init_done  <= init_done_n;
`endif
    end
  end

  // Backlight/power pin follows the request one cycle later, independent of the FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lcd_on_o <= 1'b0;
    else         lcd_on_o <= lcd_on_i;
  end

endmodule
